fetch_prefetch_stage: RTL and testbench

- IF stage of Pipeline_RISCV: owns the PC, issues in-order requests to instruction memory over a ready/valid interface, and buffers returned words in a DEPTH-entry prefetch queue.
- Drives the IF/ID register consumed by Decode (InstrD, PCD, PCPlus4D).
- Honours StallD/FlushD from the hazard unit and branch/jump redirects from Execute, and discards stale in-flight responses after a redirect.

---
 rtl/fetch_prefetch_stage.sv | 163 ++++++++++++++++
 tb/tb_fetch_prefetch_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_stage.sv
// IF stage: owns the PC, issues in-order imem requests and buffers returned words in a
// DEPTH-entry prefetch queue feeding IF/ID. Optional perf counters under `FETCH_PERF_EN.
module fetch_prefetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles,
`endif
    output logic        ValidD
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0]   L_DEPTH = (CW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [31:0]   r_pc;
    logic [31:0]   r_rsp_pc;
    logic [31:0]   r_q_instr [DEPTH];
    logic [31:0]   r_q_pc    [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;
    logic [31:0]   r_instr_d;
    logic [31:0]   r_pc_d;
    logic [31:0]   r_pcp4_d;
    logic          r_valid_d;

    logic [CW:0]   w_occ;
    logic          w_req_valid;
    logic          w_accept;
    logic          w_kill;
    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_out_after;

    always_comb begin
        w_occ       = {1'b0, r_out} + {1'b0, r_count};
        w_req_valid = !rst && !PCSrcE && (w_occ < L_DEPTH);
        w_accept    = w_req_valid && imem_req_ready;
        w_kill      = FlushD || PCSrcE;
        w_pop       = !w_kill && !StallD && (r_count != '0);
        w_push      = imem_rsp_valid && !PCSrcE && (r_drop == '0);
        w_out_after = r_out - CW'(imem_rsp_valid);
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign InstrD         = r_instr_d;
    assign PCD            = r_pc_d;
    assign PCPlus4D       = r_pcp4_d;
    assign ValidD         = r_valid_d;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= imem_rsp_data;
            r_q_pc[r_wr_ptr]    <= r_rsp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_rsp_pc <= RESET_PC;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_out    <= '0;
            r_drop   <= '0;
        end else begin
            r_out <= w_out_after + CW'(w_accept);
            if (PCSrcE) begin
                r_pc     <= {PCTargetE[31:2], 2'b00};
                r_rsp_pc <= {PCTargetE[31:2], 2'b00};
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                // Every response still in flight belongs to the old path.
                r_drop   <= w_out_after;
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                end
                if (imem_rsp_valid && (r_drop != '0)) begin
                    r_drop <= r_drop - CNT_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_d <= NOP;
            r_pc_d    <= '0;
            r_pcp4_d  <= '0;
            r_valid_d <= 1'b0;
        end else if (w_kill) begin
            r_instr_d <= NOP;
            r_valid_d <= 1'b0;
        end else if (!StallD) begin
            if (r_count != '0) begin
                r_instr_d <= r_q_instr[r_rd_ptr];
                r_pc_d    <= r_q_pc[r_rd_ptr];
                r_pcp4_d  <= r_q_pc[r_rd_ptr] + 32'd4;
                r_valid_d <= 1'b1;
            end else begin
                r_instr_d <= NOP;
                r_valid_d <= 1'b0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_bubbles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_bubbles <= '0;
        end else begin
            if (w_accept && (r_perf_fetched != '1)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (!w_kill && !StallD && (r_count == '0) && (r_perf_bubbles != '1)) begin
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_bubbles = r_perf_bubbles;
`endif

endmodule

// File: tb/tb_fetch_prefetch_stage.sv
// Bench for fetch_prefetch_stage: queue-based reference model plus in-order memory model
// with programmable latency; directed scenarios with literal spot checks.
module tb_fetch_prefetch_stage;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    fetch_prefetch_stage #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (DEPTH),
        .NOP     (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_addr (imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .StallD        (StallD),
        .FlushD        (FlushD),
        .PCSrcE        (PCSrcE),
        .PCTargetE     (PCTargetE),
        .InstrD        (InstrD),
        .PCD           (PCD),
        .PCPlus4D      (PCPlus4D),
`ifdef FETCH_PERF_EN
        .perf_fetched  (perf_fetched),
        .perf_bubbles  (perf_bubbles),
`endif
        .ValidD        (ValidD)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int lat   = 1;

    typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
    typedef struct {logic [31:0] addr; int due;} mreq_t;

    ent_t  m_q[$];
    mreq_t mq[$];
    int          m_out = 0;
    int          m_drop = 0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_rsp_pc = '0;
    logic [31:0] m_instr = NOP;
    logic [31:0] m_pcd = '0;
    logic [31:0] m_pcp4 = '0;
    logic        m_valid = 1'b0;
    logic [31:0] m_perf_f = '0;
    logic [31:0] m_perf_b = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock: present memory response, check handshake, advance model, check IF/ID.
    task automatic step();
        logic        exp_rv;
        logic        dut_acc;
        logic [31:0] dut_addr;
        ent_t        e;
        mreq_t       m;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = m.addr + 32'h100;
        end
        #1;
        exp_rv = !rst && !PCSrcE && ((m_out + m_q.size()) < DEPTH);
        chk("req_valid", imem_req_valid, exp_rv);
        if (!rst) chk("req_addr", imem_req_addr, m_pc);
        dut_acc  = imem_req_valid && imem_req_ready;
        dut_addr = imem_req_addr;

        if (rst) begin
            m_q.delete();
            m_out = 0; m_drop = 0; m_pc = '0; m_rsp_pc = '0;
            m_instr = NOP; m_pcd = '0; m_pcp4 = '0; m_valid = 1'b0;
            m_perf_f = '0; m_perf_b = '0;
            mq.delete();
        end else begin
            if (FlushD || PCSrcE) begin
                m_valid = 1'b0; m_instr = NOP;
            end else if (!StallD) begin
                if (m_q.size() > 0) begin
                    e = m_q.pop_front();
                    m_instr = e.instr; m_pcd = e.pc; m_pcp4 = e.pc + 32'd4; m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0; m_instr = NOP; m_perf_b++;
                end
            end
            if (imem_rsp_valid) begin
                m_out--;
                if (!PCSrcE) begin
                    if (m_drop > 0) m_drop--;
                    else begin
                        m_q.push_back('{pc: m_rsp_pc, instr: imem_rsp_data});
                        m_rsp_pc += 32'd4;
                    end
                end
            end
            if (exp_rv && imem_req_ready) begin
                m_pc += 32'd4; m_out++; m_perf_f++;
            end
            if (PCSrcE) begin
                m_pc = {PCTargetE[31:2], 2'b00};
                m_rsp_pc = m_pc;
                m_q.delete();
                m_drop = m_out;
            end
            if (dut_acc) mq.push_back('{addr: dut_addr, due: cyc + lat});
        end

        @(posedge clk);
        #1;
        cyc++;
        chk("ValidD", ValidD, m_valid);
        chk("InstrD", InstrD, m_instr);
        chk("PCD", PCD, m_pcd);
        chk("PCPlus4D", PCPlus4D, m_pcp4);
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, m_perf_f);
        chk("perf_bubbles", perf_bubbles, m_perf_b);
`endif
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (ValidD) break;
            step();
        end
    endtask

    logic [31:0] saved_pc;

    initial begin
        run(2);
        chk("rst_valid", ValidD, 0);
        chk("rst_instr", InstrD, NOP);
        chk("rst_pcd", PCD, 0);

        // Streaming with 1-cycle memory
        rst = 1'b0;
        run(3);
        chk("first_valid", ValidD, 1);
        chk("first_pcd", PCD, 32'h0);
        chk("first_instr", InstrD, 32'h100);
        step();
        chk("second_pcd", PCD, 32'h4);
        chk("second_instr", InstrD, 32'h104);

        // Memory not ready: queue drains to a bubble
        imem_req_ready = 1'b0;
        run(3);
        chk("drain_valid", ValidD, 0);
        chk("drain_instr", InstrD, NOP);
        chk("drain_pcd_hold", PCD, 32'hC);
        imem_req_ready = 1'b1;
        run(4);

        // Stall fills queue until the cap throttles requests
        StallD = 1'b1;
        run(5);
        #1;
        chk("stall_cap", imem_req_valid, 0);
        StallD = 1'b0;
        run(8);

        // Redirect with 3-cycle memory
        lat = 3;
        run(6);
        PCSrcE = 1'b1; PCTargetE = 32'h40;
        step();
        PCSrcE = 1'b0;
        wait_valid(20);
        chk("redir_valid", ValidD, 1);
        chk("redir_pcd", PCD, 32'h40);
        chk("redir_pcp4", PCPlus4D, 32'h44);
        chk("redir_instr", InstrD, 32'h140);
        run(4);

        // Back-to-back redirects, second target unaligned
        PCSrcE = 1'b1; PCTargetE = 32'h80;
        step();
        PCTargetE = 32'h203;
        step();
        PCSrcE = 1'b0;
        wait_valid(20);
        chk("b2b_valid", ValidD, 1);
        chk("b2b_pcd", PCD, 32'h200);
        chk("b2b_instr", InstrD, 32'h300);

        // Flush overrides stall; queue head survives
        lat = 1;
        run(6);
        saved_pc = m_pcd;
        FlushD = 1'b1; StallD = 1'b1;
        step();
        chk("flush_valid", ValidD, 0);
        chk("flush_instr", InstrD, NOP);
        FlushD = 1'b0; StallD = 1'b0;
        step();
        chk("flush_head_valid", ValidD, 1);
        chk("flush_head_pcd", PCD, saved_pc + 32'd4);

        // Reset with requests outstanding
        lat = 3;
        for (int i = 0; i < 10; i++) begin
            if (m_out == 3) break;
            step();
        end
        rst = 1'b1;
        step();
        chk("mid_rst_addr", imem_req_addr, 32'h0);
        chk("mid_rst_valid", ValidD, 0);
        chk("mid_rst_req", imem_req_valid, 0);
`ifdef FETCH_PERF_EN
        chk("mid_rst_perf", perf_fetched, 0);
`endif
        rst = 1'b0;
        lat = 1;
        run(3);
        chk("post_rst_pcd", PCD, 32'h0);
        chk("post_rst_instr", InstrD, 32'h100);

        // Mixed ready/stall pattern with 2-cycle memory
        lat = 2;
        for (int i = 0; i < 24; i++) begin
            imem_req_ready = (i % 3) != 1;
            StallD         = (i % 5) == 2;
            FlushD         = (i == 17);
            step();
        end
        imem_req_ready = 1'b1; StallD = 1'b0; FlushD = 1'b0;
        run(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
